// File: rtl/spi_master_cfg_if.sv
// Bundle of the host handshake and SPI pad signals for spi_master_cfg.
//   master modport : seen by the SPI master (host requests in, pads out)
//   slave  modport : seen by the host/slave side (mirror image)
// Parameters DATA_W / NUM_CS must match those of the attached spi_master_cfg.
interface spi_master_cfg_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 4
);
   localparam int unsigned CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   // host side
   logic              start;
   logic              cpol;
   logic              cpha;
   logic [CS_W-1:0]   cs_sel;
   logic [DATA_W-1:0] tx_data;
   logic              busy;
   logic              valid;
   logic [DATA_W-1:0] rx_data;
   // pad side
   logic              miso;
   logic              mosi;
   logic              spi_scl;
   logic [NUM_CS-1:0] spi_cs;

   modport master (
      input  start, cpol, cpha, cs_sel, tx_data, miso,
      output mosi, spi_scl, spi_cs, busy, valid, rx_data
   );

   modport slave (
      output start, cpol, cpha, cs_sel, tx_data, miso,
      input  mosi, spi_scl, spi_cs, busy, valid, rx_data
   );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master.
// One word of DATA_W bits per start request, any CPOL/CPHA mode, SCL half-period
// of CLK_DIV spi_clk cycles, MSB- or LSB-first, NUM_CS one-hot active-low selects.
// Ports:
//   spi_clk : system clock, all logic on its rising edge
//   reset   : asynchronous active-low reset
//   bus     : spi_master_cfg_if.master (start/cpol/cpha/cs_sel/tx_data/miso in,
//             mosi/spi_scl/spi_cs/busy/valid/rx_data out, all outputs registered)
module spi_master_cfg #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NUM_CS    = 4,
   parameter int unsigned CLK_DIV   = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic               spi_clk,
   input  logic               reset,
   spi_master_cfg_if.master   bus
);
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [EDGE_W-1:0] edge_cnt;   // SCL edges already produced
   logic              cpha_q;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;

   logic              tick_c;
   logic [EDGE_W-1:0] edge_num_c;
   logic              lead_c;
   logic              sample_c;
   logic              shift_c;
   logic [DATA_W-1:0] tx_next_c;
   logic [DATA_W-1:0] rx_next_c;
   logic [NUM_CS-1:0] cs_dec_c;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // Edge bookkeeping: which SCL edge fires next and what it does
   always_comb begin
      tick_c     = (div_cnt == DIV_W'(CLK_DIV - 1));
      edge_num_c = edge_cnt + 1'b1;
      lead_c     = edge_num_c[0];                    // odd edges are leading
      sample_c   = cpha_q ? ~lead_c : lead_c;
      // first bit is already on mosi and the last edge must not shift
      shift_c    = (cpha_q ? lead_c : ~lead_c) &&
                   (edge_num_c > EDGE_W'(1)) &&
                   (edge_num_c < EDGE_W'(2 * DATA_W));
      tx_next_c  = MSB_FIRST ? (tx_sh << 1) : (tx_sh >> 1);
      rx_next_c  = MSB_FIRST ? {rx_sh[DATA_W-2:0], bus.miso}
                             : {bus.miso, rx_sh[DATA_W-1:1]};
      // out-of-range index shifts the one-hot off the top, leaving all selects high
      cs_dec_c   = ~(NUM_CS'(1) << bus.cs_sel);
   end

   // Transfer FSM with registered pad and handshake outputs
   always_ff @(posedge spi_clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         edge_cnt    <= '0;
         cpha_q      <= 1'b0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         bus.mosi    <= 1'b0;
         bus.spi_scl <= 1'b0;
         bus.spi_cs  <= '1;
         bus.busy    <= 1'b0;
         bus.valid   <= 1'b0;
         bus.rx_data <= '0;
      end else begin
         bus.valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  cpha_q      <= bus.cpha;
                  tx_sh       <= bus.tx_data;
                  rx_sh       <= '0;
                  bus.spi_scl <= bus.cpol;
                  bus.spi_cs  <= cs_dec_c;
                  bus.mosi    <= first_bit(bus.tx_data);
                  bus.busy    <= 1'b1;
                  div_cnt     <= '0;
                  edge_cnt    <= '0;
                  state       <= SETUP;
               end
            end
            SETUP, XFER: begin
               if (tick_c) begin
                  div_cnt     <= '0;
                  edge_cnt    <= edge_num_c;
                  bus.spi_scl <= ~bus.spi_scl;
                  if (sample_c) begin
                     rx_sh <= rx_next_c;
                  end
                  if (shift_c) begin
                     tx_sh    <= tx_next_c;
                     bus.mosi <= first_bit(tx_next_c);
                  end
                  state <= (edge_num_c == EDGE_W'(2 * DATA_W)) ? HOLD : XFER;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (tick_c) begin
                  div_cnt     <= '0;
                  bus.spi_cs  <= '1;
                  bus.busy    <= 1'b0;
                  bus.valid   <= 1'b1;
                  bus.rx_data <= rx_sh;
                  bus.mosi    <= 1'b0;
                  state       <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule
